// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: op-codes, flag bit positions
// and the arbiter FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SEXT = 3'b101;

    // Any op-code at or above this value is rejected as illegal.
    localparam logic [2:0] ALU_OP_ILLEGAL = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] ILLEGAL_FLAGS = 4'b1 << FLAG_Z;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: combinational grant from a registered priority
// pointer that moves away from the last-served requester when updated.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_en_i,
    input  logic       served_id_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // NOTE: combinational blocks assign every output a default first so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    assign ptr_d = upd_en_i ? ~served_id_i : ptr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one integer ALU between two requesters: round-robin accept, registered
// ALU operands, programmable result latency, tagged valid/ready response.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy
);

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

    arb_state_e        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [DATA_W-1:0] alu_a_q,      alu_a_d;
    logic [DATA_W-1:0] alu_b_q,      alu_b_d;
    logic [OP_W-1:0]   alu_ctrl_q,   alu_ctrl_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_flags_q,  rsp_flags_d;
    logic              rsp_err_q,    rsp_err_d;

    logic              idle;
    logic [1:0]        gnt;
    logic              accept;
    logic              acc_id;
    logic [DATA_W-1:0] acc_a;
    logic [DATA_W-1:0] acc_b;
    logic [OP_W-1:0]   acc_op;
    logic              rsp_hs;

    assign idle   = (state_q == IDLE);
    assign rsp_hs = (state_q == RESP) && rsp_ready;

    // The pointer only moves on a completed response, so an operation killed
    // by reset never costs its requester a turn.
    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst         (rst),
        .req_i       ({req1_valid, req0_valid}),
        .upd_en_i    (rsp_hs),
        .served_id_i (rsp_id_q),
        .gnt_o       (gnt)
    );

    assign req0_ready = idle && gnt[0];
    assign req1_ready = idle && gnt[1];
    assign accept     = req0_ready || req1_ready;
    assign acc_id     = gnt[1];
    assign acc_a      = acc_id ? req1_a  : req0_a;
    assign acc_b      = acc_id ? req1_b  : req0_b;
    assign acc_op     = acc_id ? req1_op : req0_op;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d    = acc_a;
                    alu_b_d    = acc_b;
                    alu_ctrl_d = acc_op;
                    rsp_id_d   = acc_id;
                    rsp_err_d  = (acc_op >= OP_W'(ALU_OP_ILLEGAL));
                    cnt_d      = CNT_LOAD;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    // Illegal ops still drive the ALU; its answer is discarded.
                    rsp_result_d = rsp_err_q ? '0 : alu_result;
                    rsp_flags_d  = rsp_err_q ? ILLEGAL_FLAGS : alu_flags;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = !idle;

endmodule
